// File: rtl/mdio_pkg.sv
// Shared definitions for the clause-22 MDIO frame engine.
// Holds the frame field constants, the FSM state type and a helper that
// assembles everything after the preamble into one shift word.
package mdio_pkg;

  localparam logic [1:0] ST     = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b01;

  localparam int FRAME_BITS = 64;
  // Everything that follows the 32-bit preamble: ST, OP, PHYAD, REGAD, TA, DATA.
  localparam int BODY_BITS  = FRAME_BITS - 32;
  localparam int HDR_BITS   = 14;
  localparam int TA_BITS    = 2;
  localparam int DATA_BITS  = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA,
    TAIL
  } state_t;

  // Reads fill TA and DATA with ones: the line is released there, so the
  // value is never driven, and keeping mdio_o high avoids needless toggling.
  function automatic logic [BODY_BITS-1:0] build_body(
    input logic        rd,
    input logic [4:0]  phy,
    input logic [4:0]  rga,
    input logic [15:0] wd
  );
    if (rd) return {ST, OP_RD, phy, rga, 2'b11, 16'hFFFF};
    else    return {ST, OP_WR, phy, rga, 2'b10, wd};
  endfunction

endpackage

// File: rtl/mdc_clkgen.sv
// MDC generator for the MDIO frame engine.
// Divides clk by CLK_DIV per half-period while en is high; mdc is held low
// and the divider cleared while en is low.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   en          - run enable (the engine's busy flag)
//   mdc         - management clock, registered
//   rise_tick   - high in the cycle whose closing edge drives mdc 0->1
//   fall_tick   - high in the cycle whose closing edge drives mdc 1->0
module mdc_clkgen #(
  parameter int CLK_DIV = 833
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          half_end;

  // The ticks anticipate the mdc edge so the engine can update its outputs
  // on the very same clk edge that moves mdc.
  assign half_end  = en && (div_cnt == LAST);
  assign rise_tick = half_end && !mdc;
  assign fall_tick = half_end &&  mdc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      mdc     <= ~mdc;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_frame_engine.sv
// Clause-22 MDIO management frame engine.
// Accepts one register access at a time, generates MDC, serialises the
// 64-bit frame on MDIO (plus one trailing idle MDC period) and returns read
// data with a one-cycle done pulse.
// Ports:
//   clk, rst_n                 - system clock, asynchronous active-low reset
//   start, rd_wr               - request strobe (taken when idle), 1 = read
//   phy_addr, reg_addr         - 5-bit PHY and register addresses
//   wr_data                    - write payload
//   busy, done                 - transaction in flight, completion pulse
//   rd_data, rd_valid, ack_err - read result, read-completion flag, no-PHY flag
//   mdc, mdio_o, mdio_oe       - management clock and tri-state data drive
//   mdio_i                     - MDIO pad input, asynchronous
module mdio_frame_engine
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 833,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rd_wr,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        ack_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
  localparam logic [5:0] TA_LAST   = 6'(TA_BITS - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

  state_t               state;
  logic [5:0]           bit_cnt;
  logic                 is_rd;
  logic                 ack_bit;
  logic                 mdio_sync_p0;
  logic                 mdio_sync_p1;
  logic [BODY_BITS-1:0] tx_sr;
  logic [15:0]          rx_sr;
  logic                 rise_tick;
  logic                 fall_tick;
  logic                 accept;
  logic                 last_bit;
  logic                 tx_adv;

  mdc_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (busy),
    .mdc      (mdc),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  assign accept = (state == IDLE) && start;

  always_comb begin
    last_bit = 1'b0;
    case (state)
      PRE:     last_bit = (bit_cnt == PRE_LAST);
      HDR:     last_bit = (bit_cnt == HDR_LAST);
      TA:      last_bit = (bit_cnt == TA_LAST);
      DATA:    last_bit = (bit_cnt == DATA_LAST);
      TAIL:    last_bit = 1'b1;
      default: last_bit = 1'b0;
    endcase
  end

  // A new body bit is presented on every MDC fall from the last preamble bit
  // up to (not including) the DATA->TAIL boundary.
  assign tx_adv = fall_tick &&
                  ((state == PRE && last_bit) || state == HDR || state == TA ||
                   (state == DATA && !last_bit));

  // ---- stage p0/p1: two-flop synchroniser on the asynchronous pad input ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdio_sync_p0 <= 1'b1;
      mdio_sync_p1 <= 1'b1;
    end else begin
      mdio_sync_p0 <= mdio_i;
      mdio_sync_p1 <= mdio_sync_p0;
    end
  end

  // ---- frame datapath: transmit and receive shift registers ----
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr <= build_body(rd_wr, phy_addr, reg_addr, wr_data);
    end else if (tx_adv) begin
      tx_sr <= {tx_sr[BODY_BITS-2:0], 1'b1};
    end
    if (rise_tick && state == DATA) begin
      rx_sr <= {rx_sr[14:0], mdio_sync_p1};
    end
  end

  // ---- frame control: FSM and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      is_rd    <= 1'b0;
      ack_bit  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      ack_err  <= 1'b0;
      rd_data  <= '0;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PRE;
            bit_cnt <= '0;
            is_rd   <= rd_wr;
            ack_bit <= 1'b0;
            busy    <= 1'b1;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b1;
          end
        end
        TAIL: begin
          if (fall_tick) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            rd_valid <= is_rd;
            ack_err  <= is_rd & ack_bit;
            if (is_rd) rd_data <= rx_sr;
          end
        end
        default: begin
          // A present PHY pulls the second turnaround bit low.
          if (rise_tick && state == TA && bit_cnt == TA_LAST && is_rd) begin
            ack_bit <= mdio_sync_p1;
          end
          if (fall_tick) begin
            if (last_bit) begin
              bit_cnt <= '0;
              case (state)
                PRE:     state <= HDR;
                HDR:     state <= TA;
                TA:      state <= DATA;
                default: state <= TAIL;
              endcase
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (tx_adv) mdio_o <= tx_sr[BODY_BITS-1];
            // Reads hand the line to the PHY for turnaround and data.
            if (state == HDR && last_bit && is_rd) mdio_oe <= 1'b0;
            if (state == DATA && last_bit) begin
              mdio_oe <= 1'b0;
              mdio_o  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_frame_engine.sv
// Directed bench for mdio_frame_engine with CLK_DIV = 4.
module tb_mdio_frame_engine;

  localparam int CD  = 4;
  localparam int LAT = 1 + 130 * CD;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        rd_wr    = 1'b0;
  logic [4:0]  phy_addr = '0;
  logic [4:0]  reg_addr = '0;
  logic [15:0] wr_data  = '0;
  logic        busy, done, rd_valid, ack_err, mdc, mdio_o, mdio_oe, mdio_i;
  logic [15:0] rd_data;

  logic        phy_present = 1'b0;
  logic [15:0] phy_data    = '0;
  logic        phy_en, phy_bit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdio_frame_engine #(
    .CLK_DIV(CD),
    .PRE_LEN(32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rd_wr   (rd_wr),
    .phy_addr(phy_addr),
    .reg_addr(reg_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .ack_err (ack_err),
    .mdc     (mdc),
    .mdio_o  (mdio_o),
    .mdio_oe (mdio_oe),
    .mdio_i  (mdio_i)
  );

  // Line monitor: records each bit at MDC rise, counts MDC falls (= index of
  // the bit currently on the wire), counts done pulses and flags any output
  // change that is not on an MDC fall or the first-bit cycle.
  int   rise_idx = 0;
  int   fall_idx = 0;
  int   done_cnt = 0;
  int   chg_viol = 0;
  logic prev_mdc = 1'b0, prev_busy = 1'b0, prev_o = 1'b1, prev_oe = 1'b0;
  logic rec_o  [0:64];
  logic rec_oe [0:64];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mdc  <= 1'b0;
      prev_busy <= 1'b0;
      prev_o    <= mdio_o;
      prev_oe   <= mdio_oe;
    end else begin
      if (busy && !prev_busy) begin
        rise_idx <= 0;
        fall_idx <= 0;
      end else begin
        if (mdc && !prev_mdc) begin
          if (rise_idx <= 64) begin
            rec_o[rise_idx]  <= mdio_o;
            rec_oe[rise_idx] <= mdio_oe;
          end
          rise_idx <= rise_idx + 1;
        end
        if (!mdc && prev_mdc) fall_idx <= fall_idx + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if ((mdio_o != prev_o || mdio_oe != prev_oe) &&
          !(!mdc && prev_mdc) && !(busy && !prev_busy))
        chg_viol <= chg_viol + 1;
      prev_mdc  <= mdc;
      prev_busy <= busy;
      prev_o    <= mdio_o;
      prev_oe   <= mdio_oe;
    end
  end

  // PHY model: drives TA bit 1 low and the 16 data bits MSB first when
  // present; otherwise the pull-up reads as 1.
  always_comb begin
    phy_en  = 1'b0;
    phy_bit = 1'b1;
    if (phy_present && busy) begin
      if (fall_idx == 47) begin
        phy_en  = 1'b1;
        phy_bit = 1'b0;
      end else if (fall_idx >= 48 && fall_idx <= 63) begin
        phy_en  = 1'b1;
        phy_bit = phy_data[4'(63 - fall_idx)];
      end
    end
  end

  assign mdio_i = mdio_oe ? mdio_o : (phy_en ? phy_bit : 1'b1);

  typedef struct {
    string       name;
    logic        rd;
    logic [4:0]  phy;
    logic [4:0]  rga;
    logic [15:0] wd;
    logic        present;
    logic [15:0] pdata;
    logic [63:0] frame;
    logic [63:0] mask;
    logic [15:0] exp_rd;
    logic        exp_rv;
    logic        exp_ack;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(input string nm, input logic rd, input logic [4:0] phy,
                              input logic [4:0] rga, input logic [15:0] wd,
                              input logic present, input logic [15:0] pdata,
                              input logic [63:0] frame, input logic [63:0] mask,
                              input logic [15:0] exp_rd, input logic exp_rv,
                              input logic exp_ack);
    vec_t v;
    v.name = nm; v.rd = rd; v.phy = phy; v.rga = rga; v.wd = wd;
    v.present = present; v.pdata = pdata; v.frame = frame; v.mask = mask;
    v.exp_rd = exp_rd; v.exp_rv = exp_rv; v.exp_ack = exp_ack;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_frame(input string nm, input logic [63:0] ef, input logic [63:0] em);
    logic [63:0] ao, aoe;
    for (int i = 0; i < 64; i++) begin
      ao[63-i]  = rec_o[i];
      aoe[63-i] = rec_oe[i];
    end
    chk({nm, " frame_bits"}, ao & em, ef & em);
    chk({nm, " oe_map"}, aoe, em);
    chk({nm, " tail_oe"}, 64'(rec_oe[64]), 64'd0);
    chk({nm, " mdc_rises"}, 64'(rise_idx), 64'd65);
  endtask

  // Runs one request; inj >= 0 pulses a conflicting start that many cycles
  // after the accept.
  task automatic run_txn(input vec_t v, input int inj);
    int n;
    phy_present = v.present;
    phy_data    = v.pdata;
    @(negedge clk);
    rd_wr = v.rd; phy_addr = v.phy; reg_addr = v.rga; wr_data = v.wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({v.name, " busy_t1"}, 64'(busy), 64'd1);
    while (!done && n < LAT + 100) begin
      @(negedge clk);
      n++;
      if (inj >= 0) begin
        if (n == inj) begin
          start = 1'b1; rd_wr = ~v.rd; phy_addr = 5'h15; reg_addr = 5'h0A; wr_data = 16'hDEAD;
        end else begin
          start = 1'b0;
        end
      end
    end
    chk({v.name, " done_latency"}, 64'(n), 64'(LAT));
    chk({v.name, " busy_at_done"}, 64'(busy), 64'd0);
    chk({v.name, " rd_valid"}, 64'(rd_valid), 64'(v.exp_rv));
    chk({v.name, " rd_data"}, 64'(rd_data), 64'(v.exp_rd));
    chk({v.name, " ack_err"}, 64'(ack_err), 64'(v.exp_ack));
    check_frame(v.name, v.frame, v.mask);
    @(negedge clk);
    chk({v.name, " done_pulse_end"}, 64'(done), 64'd0);
    chk({v.name, " rd_valid_end"}, 64'(rd_valid), 64'd0);
    chk({v.name, " ack_err_held"}, 64'(ack_err), 64'(v.exp_ack));
  endtask

  initial begin
    int n;
    int d0;
    vecs[0] = mk("wr_p1r0", 1'b0, 5'd1, 5'd0, 16'h1200, 1'b0, 16'h0000,
                 64'hFFFF_FFFF_5082_1200, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0, 1'b0);
    vecs[1] = mk("rd_p1r2", 1'b1, 5'd1, 5'd2, 16'h0000, 1'b1, 16'h0141,
                 64'hFFFF_FFFF_6088_0000, 64'hFFFF_FFFF_FFFC_0000, 16'h0141, 1'b1, 1'b0);
    vecs[2] = mk("rd_nophy", 1'b1, 5'd3, 5'd1, 16'h0000, 1'b0, 16'h0000,
                 64'hFFFF_FFFF_6184_0000, 64'hFFFF_FFFF_FFFC_0000, 16'hFFFF, 1'b1, 1'b1);
    vecs[3] = mk("wr_p31r31", 1'b0, 5'h1F, 5'h1F, 16'hA5C3, 1'b0, 16'h0000,
                 64'hFFFF_FFFF_5FFE_A5C3, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 1'b0, 1'b0);
    vecs[4] = mk("rd_p0r31", 1'b1, 5'd0, 5'h1F, 16'h0000, 1'b1, 16'h8001,
                 64'hFFFF_FFFF_607C_0000, 64'hFFFF_FFFF_FFFC_0000, 16'h8001, 1'b1, 1'b0);

    // Reset state, during and after reset
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst mdc", 64'(mdc), 64'd0);
    chk("rst mdio_o", 64'(mdio_o), 64'd1);
    chk("rst mdio_oe", 64'(mdio_oe), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle done", 64'(done), 64'd0);
    chk("idle rd_valid", 64'(rd_valid), 64'd0);
    chk("idle ack_err", 64'(ack_err), 64'd0);
    chk("idle rd_data", 64'(rd_data), 64'd0);
    chk("idle mdc", 64'(mdc), 64'd0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], -1);

    // Start while busy is ignored
    d0 = done_cnt;
    run_txn(vecs[4], 50);
    repeat (100) @(negedge clk);
    chk("ignored_start done_count", 64'(done_cnt - d0), 64'd1);
    chk("ignored_start busy", 64'(busy), 64'd0);

    // Back-to-back: start held, second request taken in the done cycle
    phy_present = 1'b0;
    @(negedge clk);
    rd_wr = 1'b0; phy_addr = 5'd1; reg_addr = 5'd0; wr_data = 16'h1200; start = 1'b1;
    @(negedge clk);
    n = 1;
    phy_addr = 5'h1F; reg_addr = 5'h1F; wr_data = 16'hA5C3;
    while (!done && n < LAT + 100) begin @(negedge clk); n++; end
    chk("b2b first latency", 64'(n), 64'(LAT));
    chk("b2b busy_at_done", 64'(busy), 64'd0);
    chk("b2b mdc_at_done", 64'(mdc), 64'd0);
    chk("b2b rd_valid", 64'(rd_valid), 64'd0);
    check_frame("b2b first", vecs[0].frame, vecs[0].mask);
    @(negedge clk);
    start = 1'b0;
    chk("b2b second accepted", 64'(busy), 64'd1);
    n = 1;
    while (!done && n < LAT + 100) begin @(negedge clk); n++; end
    chk("b2b done_spacing", 64'(n), 64'(LAT));
    check_frame("b2b second", vecs[3].frame, vecs[3].mask);

    // Reset in the middle of a frame, at bit 40
    @(negedge clk);
    rd_wr = 1'b0; phy_addr = 5'd1; reg_addr = 5'd0; wr_data = 16'h1200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (fall_idx != 40 && n < LAT) begin @(negedge clk); n++; end
    chk("abort reached bit40", 64'(fall_idx), 64'd40);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort mdc", 64'(mdc), 64'd0);
    chk("abort mdio_oe", 64'(mdio_oe), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort mdio_o", 64'(mdio_o), 64'd1);
    chk("abort rd_data", 64'(rd_data), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 50) @(negedge clk);
    chk("abort no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort idle", 64'(busy), 64'd0);
    run_txn(vecs[0], -1);

    chk("outputs_only_on_fall", 64'(chg_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdio_frame_engine.md
# mdio_frame_engine

Serial MDIO management-frame engine on the Ethernet PHY side of the AD9226/RGMII path. It accepts one register-access request at a time from the PHY configuration controller (start, read/write, PHY address, register address, write data) and generates MDC. It serialises a complete IEEE 802.3 clause-22 frame on MDIO and returns read data plus a completion pulse. It is the direct downstream consumer of the configuration sequencer's request/done handshake.

## Interface
- CLK_DIV, 833: clk cycles per MDC half-period; 833 gives about 30 kHz from 50 MHz; legal range ≥ 4.
- PRE_LEN, 32: number of preamble '1' bits.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; accepted only when busy = 0.
- rd_wr  in  1  1 = read, 0 = write; captured at accept.
- phy_addr  in  5  PHY address; captured at accept.
- reg_addr  in  5  register address; captured at accept.
- wr_data  in  16  write data; captured at accept.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rd_data  out  16  last read result; held until next read completes.
- rd_valid  out  1  equals done for read transactions, 0 for writes.
- ack_err  out  1  read turnaround bit sampled as 1 (no PHY); valid with done; held until the next done.
- mdc  out  1  management clock; low when idle.
- mdio_o  out  1  MDIO output data.
- mdio_oe  out  1  MDIO output enable. Top level builds the inout: mdio = oe ? o : Z, with external pull-up.
- mdio_i  in  1  MDIO input, asynchronous.

## Operation
- Frame of 64 bits, MSB first:
  - PRE_LEN × '1' preamble
  - ST = 01
  - OP = 10 for read, 01 for write
  - PHYAD[4:0], REGAD[4:0]
  - TA: write drives 10; read releases MDIO (Z0)
  - DATA[15:0]
  - one trailing idle MDC period with mdio_oe = 0.
- States and transitions:
  - IDLE → PRE on accept.
  - PRE → HDR after PRE_LEN bits.
  - HDR (14 bits) → TA.
  - TA (2 bits) → DATA.
  - DATA (16 bits) → TAIL.
  - TAIL (1 period) → IDLE, with done asserted.
- A 6-bit bit counter runs within each state.
- Outputs change only on the MDC falling edge, i.e. the clk cycle in which mdc goes 1→0. The first bit is presented in the cycle after accept, while mdc = 0.
- Read:
  - mdio_oe = 0 from the first TA bit through TAIL.
  - mdio_i passes through a 2-flop synchroniser.
  - Sampling uses the synchronised value in the cycle mdc goes 0→1.
  - The second TA bit ≠ 0 sets ack_err.
  - The 16 DATA samples shift into a register that loads rd_data at done.
- Write: mdio_oe = 1 through the end of DATA.
- start while busy = 1 is ignored; there is no queue.
- Request fields are registered at accept; later input changes have no effect on the frame in flight.
- An assertion of rst_n mid-frame aborts the frame immediately:
  - all outputs return to reset values;
  - no done pulse is produced.

## Timing
- Reset values: busy 0, done 0, rd_valid 0, ack_err 0, rd_data 0x0000, mdc 0, mdio_o 1, mdio_oe 0.
- Accept happens at cycle T (start = 1, busy = 0).
  - busy = 1 from T+1.
  - mdc first rises at T+1+CLK_DIV.
  - The MDC period is 2·CLK_DIV cycles.
- done/rd_valid pulse at T+1+130·CLK_DIV, in the same cycle as the final mdc fall. busy = 0 in that cycle.
- A start that is high in the done cycle is accepted, giving back-to-back frames. Minimum spacing between frames is the TAIL period.

## Structure
- mdio_pkg holds:
  - OP_RD = 2'b10, OP_WR = 2'b01, ST = 2'b01
  - FRAME_BITS = 64
  - state enum {IDLE, PRE, HDR, TA, DATA, TAIL}.
- Sub-module mdc_clkgen contains:
  - divider counter and mdc toggle, enabled only while busy;
  - one-cycle rise_tick/fall_tick outputs;
  - counter clear on idle.
- Top module contains the FSM, shift registers and synchroniser.

## Test plan
All scenarios use CLK_DIV = 4.
- Write phy 1, reg 0, data 0x1200 → MDIO sequence is 32×1, 01, 01, 00001, 00000, 10, 0001001000000000, then oe = 0. done at T+521; rd_valid = 0.
- Read phy 1, reg 2; PHY model drives TA 0 and data 0x0141 → rd_data = 0x0141, rd_valid = 1, ack_err = 0. oe = 0 from bit 46 onward.
- Read with no PHY (pull-up gives all 1s) → ack_err = 1, rd_data = 0xFFFF, done still produced.
- start pulsed at T+50 of an active frame → ignored; exactly one done occurs.
- rst_n asserted at bit 40 → mdc = 0, oe = 0, busy = 0 immediately; no done. A new write after release completes normally.
- start held high for two requests → second accepted in the first done cycle. The two frames are separated by exactly one idle MDC period.
